// File: rtl/adc_sample_ctrl_pkg.sv
// Shared definitions for the ADC sampling controller and its tick generator.
// Latency: n/a (types, constants and width helpers only).
// Backpressure: n/a.
package adc_sample_ctrl_pkg;

    // XADC code width
    localparam int ADC_WIDTH = 12;

    // Controller FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_SOC  = 3'd2,
        ST_CONV = 3'd3,
        ST_CAPT = 3'd4
    } state_t;

    // Width of a counter running 0..period-1
    function automatic int tick_cnt_width(input int unsigned period);
        return (period < 2) ? 1 : $clog2(period);
    endfunction

    // Width of a counter able to hold 0..limit
    function automatic int timeout_cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/adc_sample_ctrl_tick_gen.sv
// Periodic tick generator: counts 0..PERIOD-1 while run is high and wraps.
// Latency: tick is combinational, high during the cycle the count sits at PERIOD-1.
// Backpressure: none; clear (or rst) forces the count back to 0 on the next edge.
module tick_gen
    import adc_sample_ctrl_pkg::*;
#(
    parameter int unsigned PERIOD = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int CW = tick_cnt_width(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    // Free-running wrap counter, held at zero whenever cleared
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/adc_sample_ctrl.sv
// Periodic XADC sampler: SOC pulse every SAMPLE_PERIOD cycles, averages 2^AVG_LOG2 codes.
// Latency: adc_soc SAMPLE_PERIOD cycles after WAIT entry; result 2 cycles after the final EOC.
// Backpressure: data_valid held until data_ack; an unacknowledged result is overwritten and flags overrun.
module adc_sample_ctrl
    import adc_sample_ctrl_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = 1000000,
    parameter int unsigned AVG_LOG2      = 3,
    parameter int unsigned EOC_TIMEOUT   = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic                 adc_soc,
    input  logic                 adc_eoc,
    input  logic [ADC_WIDTH-1:0] adc_data,
    output logic [ADC_WIDTH-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ack,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 overrun
);

    localparam int TW = timeout_cnt_width(EOC_TIMEOUT);
    localparam int AW = ADC_WIDTH + int'(AVG_LOG2);
    localparam int NW = int'(AVG_LOG2) + 1;

    // Abort fires on the cycle whose increment would bring the count to EOC_TIMEOUT
    localparam logic [TW-1:0] TO_LAST = TW'(EOC_TIMEOUT - 1);
    localparam logic [NW-1:0] LAST_N  = NW'((1 << AVG_LOG2) - 1);

    state_t        state;
    logic [TW-1:0] to_cnt;
    logic [AW-1:0] acc;
    logic [NW-1:0] n_cnt;
    logic          abort;

    logic          tick;
    logic          tick_run;
    logic          tick_clear;
    logic [AW-1:0] acc_sum;
    logic          last_sample;
    logic          new_result;
    logic [ADC_WIDTH-1:0] avg;

    // Sample-period counter only advances in WAIT and restarts from zero on every WAIT entry
    assign tick_run   = (state == ST_WAIT);
    assign tick_clear = (state != ST_WAIT);

    tick_gen #(
        .PERIOD (SAMPLE_PERIOD)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (tick_clear),
        .run   (tick_run),
        .tick  (tick)
    );

    // Accumulator is wide enough for 2^AVG_LOG2 full-scale codes, so the sum never wraps
    assign acc_sum     = acc + AW'(adc_data);
    assign last_sample = (n_cnt == LAST_N);
    assign avg         = ADC_WIDTH'(acc_sum >> AVG_LOG2);

    // A result is published only from a capture that completes a full group while still enabled
    assign new_result  = (state == ST_CAPT) && !abort && en && last_sample;

    // Sampling FSM with registered adc_soc/busy, timeout supervision and accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            adc_soc     <= 1'b0;
            busy        <= 1'b0;
            to_cnt      <= '0;
            acc         <= '0;
            n_cnt       <= '0;
            abort       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            adc_soc <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (tick) begin
                        state   <= ST_SOC;
                        adc_soc <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_SOC: begin
                    state  <= ST_CONV;
                    to_cnt <= '0;
                    if (!en) begin
                        abort <= 1'b1;
                    end
                end
                ST_CONV: begin
                    if (!en) begin
                        abort <= 1'b1;
                    end
                    if (adc_eoc) begin
                        state <= ST_CAPT;
                    end else if (to_cnt == TO_LAST) begin
                        // Missing EOC: drop the partial group and resume the sample schedule
                        timeout_err <= 1'b1;
                        acc         <= '0;
                        n_cnt       <= '0;
                        abort       <= 1'b0;
                        busy        <= 1'b0;
                        state       <= (abort || !en) ? ST_IDLE : ST_WAIT;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                ST_CAPT: begin
                    abort <= 1'b0;
                    busy  <= 1'b0;
                    if (abort || !en) begin
                        // Disabled mid-conversion: the sample is consumed but never used
                        acc   <= '0;
                        n_cnt <= '0;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_WAIT;
                        if (last_sample) begin
                            acc   <= '0;
                            n_cnt <= '0;
                        end else begin
                            acc   <= acc_sum;
                            n_cnt <= n_cnt + NW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    abort <= 1'b0;
                end
            endcase
        end
    end

    // Result register with valid/ack handshake and sticky overrun on lost results
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (new_result) begin
            data_out   <= avg;
            data_valid <= 1'b1;
            if (data_valid && !data_ack) begin
                overrun <= 1'b1;
            end
        end else if (data_valid && data_ack) begin
            data_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Randomized bench for adc_sample_ctrl against an event-time reference model.
// Latency: checks every output on every cycle at the falling edge.
// Backpressure: random data_ack, en drops, resets and stray EOCs exercise the handshake.
`timescale 1ns/1ps
module tb_adc_sample_ctrl;

    localparam int unsigned SP = 20;
    localparam int unsigned AL = 2;
    localparam int unsigned TO = 15;
    localparam int          MAIN_CYCLES = 8000;

    logic        clk;
    logic        rst;
    logic        en, adc_eoc, data_ack;
    logic [11:0] adc_data;
    logic        adc_soc, data_valid, busy, timeout_err, overrun;
    logic [11:0] data_out;

    logic        en1, eoc1, ack1;
    logic [11:0] data1;
    logic        soc1, dv1, busy1, terr1, ovr1;
    logic [11:0] dout1;

    adc_sample_ctrl #(.SAMPLE_PERIOD(SP), .AVG_LOG2(AL), .EOC_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .en(en), .adc_soc(adc_soc), .adc_eoc(adc_eoc),
        .adc_data(adc_data), .data_out(data_out), .data_valid(data_valid),
        .data_ack(data_ack), .busy(busy), .timeout_err(timeout_err), .overrun(overrun)
    );

    adc_sample_ctrl #(.SAMPLE_PERIOD(SP), .AVG_LOG2(0), .EOC_TIMEOUT(TO)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .adc_soc(soc1), .adc_eoc(eoc1),
        .adc_data(data1), .data_out(dout1), .data_valid(dv1),
        .data_ack(ack1), .busy(busy1), .timeout_err(terr1), .overrun(ovr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: the controller is idle, waiting for a scheduled SOC, or busy with one conversion
    typedef enum {M_IDLE, M_WAIT, M_BUSY} mode_e;
    mode_e       m_mode;
    int          next_soc, soc_cyc, eoc_cyc, data_cyc, end_cyc;
    bit          m_tmo, m_abort;
    logic [11:0] m_sample;
    logic [11:0] samples[$];
    logic [11:0] e_dout;
    bit          e_valid, e_terr, e_ovr;
    int          conv_cnt = 0;
    int          n_res = 0;

    function automatic void model_reset();
        m_mode   = M_IDLE;
        samples.delete();
        e_valid  = 0;
        e_dout   = '0;
        e_terr   = 0;
        e_ovr    = 0;
        m_abort  = 0;
        next_soc = -1;
        soc_cyc  = -1;
        eoc_cyc  = -1;
        data_cyc = -1;
        end_cyc  = -1;
    endfunction

    initial begin
        int          d;
        int          sum;
        bit          new_res;
        logic [11:0] res;
        int          exp_soc1, eoc1c, res1;

        rst = 1'b1; en = 1'b0; adc_eoc = 1'b0; data_ack = 1'b0; adc_data = '0;
        en1 = 1'b0; eoc1 = 1'b0; ack1 = 1'b1; data1 = '0;
        repeat (2) @(negedge clk);
        cyc = 0;
        model_reset();

        for (int it = 0; it < MAIN_CYCLES; it++) begin
            // A scheduled SOC starts a conversion; the ADC behaviour for it is chosen now
            if (m_mode == M_WAIT && cyc == next_soc) begin
                m_mode  = M_BUSY;
                soc_cyc = cyc;
                m_abort = 0;
                if (conv_cnt < 8) begin
                    m_tmo    = 0;
                    d        = 5;
                    m_sample = (conv_cnt < 4) ? 12'(12'h100 + 2 * conv_cnt) : 12'($urandom);
                end else begin
                    m_tmo    = ($urandom_range(0, 4) == 0);
                    d        = int'($urandom_range(1, TO));
                    m_sample = 12'($urandom);
                end
                conv_cnt++;
                eoc_cyc  = m_tmo ? -1 : cyc + d;
                data_cyc = m_tmo ? -1 : cyc + d + 1;
                end_cyc  = m_tmo ? cyc + int'(TO) : cyc + d + 1;
            end

            chk("adc_soc", adc_soc, (m_mode == M_BUSY && cyc == soc_cyc));
            chk("busy", busy, (m_mode == M_BUSY));
            chk("data_valid", data_valid, e_valid);
            chk("data_out", data_out, e_dout);
            chk("timeout_err", timeout_err, e_terr);
            chk("overrun", overrun, e_ovr);

            // Inputs for this cycle
            if (n_res < 2) begin
                rst = 1'b0; en = 1'b1; data_ack = 1'b0;
            end else begin
                rst = ($urandom_range(0, 699) == 0) ||
                      (m_mode == M_BUSY && cyc == data_cyc && e_valid && $urandom_range(0, 3) == 0);
                if (en) en = ($urandom_range(0, 149) != 0);
                else    en = ($urandom_range(0, 7) == 0);
                data_ack = ($urandom_range(0, 2) == 0);
            end
            adc_eoc  = (m_mode == M_BUSY) ? (cyc == eoc_cyc) : (n_res >= 2 && $urandom_range(0, 9) == 0);
            adc_data = (m_mode == M_BUSY && cyc == data_cyc) ? m_sample : 12'($urandom);

            // Advance the model to the next cycle
            new_res = 0;
            res     = '0;
            if (rst) begin
                model_reset();
            end else begin
                case (m_mode)
                    M_IDLE: if (en) begin m_mode = M_WAIT; next_soc = cyc + 1 + int'(SP); end
                    M_WAIT: if (!en) m_mode = M_IDLE;
                    M_BUSY: begin
                        if (!en) m_abort = 1;
                        if (cyc == end_cyc) begin
                            if (m_tmo) e_terr = 1;
                            if (m_abort) begin
                                samples.delete();
                                m_mode = M_IDLE;
                            end else begin
                                m_mode   = M_WAIT;
                                next_soc = cyc + 1 + int'(SP);
                                if (m_tmo) begin
                                    samples.delete();
                                end else begin
                                    samples.push_back(m_sample);
                                    if (samples.size() == (1 << AL)) begin
                                        sum = 0;
                                        foreach (samples[i]) sum += int'(samples[i]);
                                        res     = 12'(sum >> AL);
                                        new_res = 1;
                                        n_res++;
                                        samples.delete();
                                    end
                                end
                            end
                        end
                    end
                    default: m_mode = M_IDLE;
                endcase
                if (new_res) begin
                    if (e_valid && !data_ack) e_ovr = 1;
                    e_valid = 1;
                    e_dout  = res;
                end else if (e_valid && data_ack) begin
                    e_valid = 0;
                end
            end

            @(negedge clk);
            cyc++;
        end

        // Single-sample averaging: every full-scale code must come through unchanged
        rst = 1'b0; en = 1'b0; adc_eoc = 1'b0; data_ack = 1'b0;
        en1 = 1'b1;
        exp_soc1 = cyc + 1 + int'(SP);
        eoc1c = -1;
        res1  = -1;
        for (int it = 0; it < 160; it++) begin
            @(negedge clk);
            cyc++;
            chk("avg0_soc", soc1, (cyc == exp_soc1));
            chk("avg0_valid", dv1, (cyc == res1));
            if (cyc == res1) chk("avg0_data", dout1, 12'hFFF);
            chk("avg0_overrun", ovr1, 1'b0);
            if (cyc == exp_soc1) begin
                eoc1c    = cyc + 3;
                res1     = cyc + 5;
                exp_soc1 = cyc + 5 + int'(SP);
            end
            eoc1  = (cyc == eoc1c);
            data1 = (cyc == eoc1c + 1) ? 12'hFFF : 12'($urandom_range(0, 12'h7FF));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_sample_ctrl.md
ADC_SAMPLE_CTRL -- requirements
Module: adc_sample_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_PERIOD, default 1000000, clk cycles between sample starts (10 ms at 100 MHz); legal range 16..2^24.
REQ-002 SHALL have parameter AVG_LOG2, default 3, log2 of samples averaged per result; legal range 0..4.
REQ-003 SHALL have parameter EOC_TIMEOUT, default 1023, maximum clk cycles from SOC to EOC before abort.
REQ-004 SHALL have port clk  in  1  on-board 100 MHz system clock, also the XADC clock.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  in  1  enables periodic sampling.
REQ-007 SHALL have port adc_soc  out  1  start-of-conversion, single clk pulse, to XADC AdcSoc.
REQ-008 SHALL have port adc_eoc  in  1  end-of-conversion from XADC AdcEoc.
REQ-009 SHALL have port adc_data  in  12  registered XADC code, valid from the cycle after adc_eoc.
REQ-010 SHALL have port data_out  out  12  averaged ADC code.
REQ-011 SHALL have port data_valid  out  1  result available; held until data_ack.
REQ-012 SHALL have port data_ack  in  1  consumer accepts result (e.g. UART TX load).
REQ-013 SHALL have port busy  out  1  high in any state other than IDLE and WAIT.
REQ-014 SHALL have port timeout_err  out  1  sticky, EOC timeout occurred.
REQ-015 SHALL have port overrun  out  1  sticky, unacknowledged result overwritten.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, SOC, CONV, CAPT.
REQ-017 SHALL leave IDLE for WAIT when en=1; the tick counter SHALL clear to 0 on that transition.
REQ-018 In WAIT, the tick counter SHALL count 0..SAMPLE_PERIOD-1 and wrap; on reaching SAMPLE_PERIOD-1 the FSM SHALL go to SOC.
REQ-019 In SOC (one cycle), adc_soc SHALL be 1; the FSM SHALL then go to CONV with the timeout counter cleared; adc_soc SHALL be 0 in every other state.
REQ-020 In CONV, adc_eoc=1 SHALL move the FSM to CAPT; the timeout counter reaching EOC_TIMEOUT first SHALL set timeout_err, clear the accumulator and sample count, and move to WAIT.
REQ-021 In CAPT (one cycle), adc_data SHALL be added to an accumulator of width 12+AVG_LOG2 (no overflow possible), and the sample count SHALL be incremented.
REQ-022 When the sample count reaches 2^AVG_LOG2, the next-cycle data_out SHALL equal accumulator >> AVG_LOG2 (truncated); data_valid SHALL go to 1; accumulator and count SHALL clear.
REQ-023 Sampling latency: adc_soc SHALL occur exactly SAMPLE_PERIOD cycles after the previous WAIT entry; ticks SHALL not be counted outside WAIT.
REQ-024 data_valid SHALL clear on the cycle after data_ack=1 while data_valid=1; data_ack while data_valid=0 SHALL be ignored.
REQ-025 A new result while data_valid=1 and data_ack=0 SHALL overwrite data_out, keep data_valid=1, and set overrun; a simultaneous data_ack and new result SHALL leave data_valid=1 with the new value, with no overrun.
REQ-026 en=0 in WAIT or IDLE SHALL go to IDLE at once; en=0 in SOC, CONV or CAPT SHALL let the conversion finish (EOC or timeout) and then go to IDLE, discarding the partial accumulation.
REQ-027 adc_eoc outside CONV SHALL be ignored.

Reset
REQ-028 rst=1 SHALL, on the next clk edge and in any state, set FSM=IDLE, all counters and the accumulator to 0, adc_soc=0, data_out=12'h000, data_valid=0, timeout_err=0, overrun=0; busy SHALL then read 0.
REQ-029 Sticky flags SHALL clear only on rst.

Structure
REQ-030 A shared package/header SHALL hold the FSM state encoding, ADC_WIDTH=12, and the counter width derivations (clog2 of SAMPLE_PERIOD and EOC_TIMEOUT).
REQ-031 The periodic counter SHALL be a sub-module tick_gen (clk, rst, clear, run, tick) reused by other practicum blocks.

Verification (SAMPLE_PERIOD=20, AVG_LOG2=2, EOC_TIMEOUT=15)
REQ-032 en=1; model EOC 5 cycles after SOC with data 0x100,0x102,0x104,0x106 -> adc_soc pulses 20 cycles after each WAIT entry, data_out=0x103, data_valid=1.
REQ-033 Model never asserts EOC -> timeout_err=1 16 cycles after SOC; FSM returns to WAIT; next result uses 4 fresh samples.
REQ-034 data_ack never asserted across two results -> overrun=1, data_out equals second average; ack on the cycle of the new result -> overrun stays 0.
REQ-035 en=0 during CONV -> EOC still consumed, no data_valid, FSM ends in IDLE, no further adc_soc.
REQ-036 rst pulsed during CAPT with data_valid=1 -> all outputs zero next cycle; the first result after re-enable ignores pre-reset samples.
REQ-037 AVG_LOG2=0, data 0xFFF -> data_out=0xFFF after each single sample, with no truncation error.
